// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle control FSM for the 16-bit accumulator/stack datapath
module mc_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [8:0] func,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mdr_write,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] reg_src,
    output logic       instr_done,
    output logic       halted,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEM_RD, S_EXEC_P, S_EXEC_R, S_MOVE, S_HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    localparam logic             TO_EN    = (MEM_TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       err_q;
    logic             timeout;
    logic             func_ok;

    // Timeout fires only on a low-ready cycle; a ready on the last allowed cycle wins.
    assign timeout  = TO_EN && !mem_ready && (wait_cnt == CNT_LAST);
    assign func_ok  = $onehot(func) && !func[8];
    assign err_code = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            err_q    <= 2'd0;
        end else begin
            case (state)
                S_FETCH, S_MEM_RD: begin
                    if (mem_ready) begin
                        state    <= (state == S_FETCH) ? S_DECODE : S_EXEC_P;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state <= S_HALT;
                        err_q <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    case (opcode)
                        3'd0, 3'd1, 3'd4, 3'd5: state <= S_MEM_RD;
                        3'd3:                   state <= S_FETCH;
                        3'd2: begin
                            if (!func_ok) begin
                                state <= S_HALT;
                                err_q <= 2'd2;
                            end else if (func[0] || func[1]) begin
                                state <= S_MOVE;
                            end else if (func[7]) begin
                                state <= S_FETCH;
                            end else begin
                                state <= S_EXEC_R;
                            end
                        end
                        default: begin
                            state <= S_HALT;
                            err_q <= 2'd1;
                        end
                    endcase
                end
                S_EXEC_P, S_EXEC_R, S_MOVE: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs decode the current state; rst forces the quiet pattern so nothing strobes mid-abort.
    always_comb begin
        mem_read     = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        mdr_write    = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 3'd7;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        reg_src      = 2'd0;
        instr_done   = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_b_sel = 1'b1;
                    alu_op    = 3'd0;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    instr_done = (opcode == 3'd3) || (opcode == 3'd2 && func_ok && func[7]);
                end
                S_MEM_RD: begin
                    mem_read     = 1'b1;
                    mem_addr_sel = 1'b1;
                    mdr_write    = mem_ready;
                end
                S_EXEC_P: begin
                    alu_a_sel  = 2'd1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    case (opcode)
                        3'd0:    alu_op = 3'd0;
                        3'd1:    alu_op = 3'd1;
                        3'd4:    alu_op = 3'd2;
                        3'd5:    alu_op = 3'd3;
                        default: alu_op = 3'd7;
                    endcase
                end
                S_EXEC_R: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    alu_a_sel  = 2'd2;
                    if (func[2])      alu_op = 3'd0;
                    else if (func[3]) alu_op = 3'd1;
                    else if (func[4]) alu_op = 3'd2;
                    else if (func[5]) alu_op = 3'd3;
                    else begin
                        alu_a_sel = 2'd3;
                        alu_op    = 3'd4;
                    end
                end
                S_MOVE: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = func[0];
                    reg_src    = func[0] ? 2'd1 : 2'd2;
                end
                default: halted = 1'b1;
            endcase
        end
    end

endmodule
